// File: rtl/player_pkg.sv
// Shared types and constants for the grid-player controller.
//   player_state_t : life state reported on the state output
//   STATE_W        : width of the state output
//   NUMBOMB_W      : width of the bomb inventory output
//   MAXBOMB_CEIL   : largest inventory capacity the output width can hold
package player_pkg;

  localparam int unsigned STATE_W      = 2;
  localparam int unsigned NUMBOMB_W    = 4;
  localparam int unsigned MAXBOMB_CEIL = 15;

  typedef enum logic [STATE_W-1:0] {
    ALIVE  = 2'd0,
    DEAD   = 2'd1,
    INVULN = 2'd2
  } player_state_t;

endpackage

// File: rtl/player_if.sv
// Player bus: keyboard levels and map feedback in, position/bomb/state out.
//   slave  : the player controller (consumes controls, drives outputs)
//   master : the environment (keyboard decoder and map/bomb engine)
// Signals: up/down/left/right/attack levels, walkAble mask (bit HTILES*v+h),
// bombHere, hit; curh/curv, placeBomb pulse, bombh/bombv, numBomb, state.
interface player_if
  import player_pkg::*;
#(
  parameter int unsigned HTILES = 10,
  parameter int unsigned VTILES = 6
) ();

  localparam int unsigned HW = $clog2(HTILES);
  localparam int unsigned VW = $clog2(VTILES);

  logic                     up;
  logic                     down;
  logic                     left;
  logic                     right;
  logic                     attack;
  logic [HTILES*VTILES-1:0] walkAble;
  logic                     bombHere;
  logic                     hit;

  logic [HW-1:0]            curh;
  logic [VW-1:0]            curv;
  logic                     placeBomb;
  logic [HW-1:0]            bombh;
  logic [VW-1:0]            bombv;
  logic [NUMBOMB_W-1:0]     numBomb;
  logic [STATE_W-1:0]       state;

  modport slave (
    input  up, down, left, right, attack, walkAble, bombHere, hit,
    output curh, curv, placeBomb, bombh, bombv, numBomb, state
  );

  modport master (
    output up, down, left, right, attack, walkAble, bombHere, hit,
    input  curh, curv, placeBomb, bombh, bombv, numBomb, state
  );

endinterface

// File: rtl/player_ctrl_cd_counter.sv
// Saturating cooldown counter: counts 0..LIMIT-1 while enabled, then holds.
// Ports: clk, rst (sync, active-high), clr (return to 0, wins over en),
// en (advance), done (counter sits at LIMIT-1).
module cd_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned W   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] TOP = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Count register; saturation is what lets the owner hold "ready" indefinitely.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + W'(1);
    end
  end

  assign done = (cnt == TOP);

endmodule

// File: rtl/player_ctrl.sv
// Grid-player controller: tile position with walkability-gated steps, bomb
// placement with a refilling inventory, and an alive/dead life state.
// Ports: clk, rst (sync, active-high), bus (player_if.slave).
// Optional feature macro PLAYER_RESPAWN_EN: DEAD times out into a respawn at
// the start tile followed by a hit-immune INVULN period. Without it DEAD is
// terminal until rst.
module player_ctrl
  import player_pkg::*;
#(
  parameter int unsigned HTILES     = 10,
  parameter int unsigned VTILES     = 6,
  parameter int unsigned MAXBOMB    = 10,
  parameter int unsigned START_H    = 0,
  parameter int unsigned START_V    = 0,
  parameter int unsigned MOVE_CD    = 2**24,
  parameter int unsigned PLACE_CD   = 2**22,
  parameter int unsigned REFILL_CD  = 2**26,
  parameter int unsigned RESPAWN_CD = 2**27,
  parameter int unsigned INVULN_CD  = 2**26
) (
  input logic     clk,
  input logic     rst,
  player_if.slave bus
);

  localparam int unsigned HW = $clog2(HTILES);
  localparam int unsigned VW = $clog2(VTILES);
  localparam int unsigned NT = HTILES * VTILES;
  localparam int unsigned IW = (NT > 1) ? $clog2(NT) : 1;

  localparam logic [NUMBOMB_W-1:0] FULL = NUMBOMB_W'(MAXBOMB);

  // An illegal parameter set leaves the player inert rather than misbehaving.
  localparam bit CFG_OK = (HTILES >= 2) && (VTILES >= 2) &&
                          (MAXBOMB >= 1) && (MAXBOMB <= MAXBOMB_CEIL) &&
                          (START_H < HTILES) && (START_V < VTILES) &&
                          (MOVE_CD >= 1) && (PLACE_CD >= 1) &&
                          (REFILL_CD >= 1) && (RESPAWN_CD >= 1) &&
                          (INVULN_CD >= 1);

  player_state_t        state_q, state_d;
  logic [HW-1:0]        curh_q, curh_d;
  logic [VW-1:0]        curv_q, curv_d;
  logic [NUMBOMB_W-1:0] numbomb_q, numbomb_d;
  logic                 placebomb_q, placebomb_d;
  logic [HW-1:0]        bombh_q, bombh_d;
  logic [VW-1:0]        bombv_q, bombv_d;

  logic move_done, place_done, refill_done;
  logic respawn_done, invuln_done;
  logic act, move_fire, place_fire, refill_en, refill_fire, respawn;
  logic dir_req, in_bounds, walk_ok;
  int   th, tv;
  logic [IW-1:0] tile_idx;

  // Cooldown timers for stepping, placing and refilling.
  cd_counter #(.LIMIT(MOVE_CD)) u_move_cd (
    .clk  (clk),
    .rst  (rst),
    .clr  (move_fire || respawn),
    .en   (1'b1),
    .done (move_done)
  );

  cd_counter #(.LIMIT(PLACE_CD)) u_place_cd (
    .clk  (clk),
    .rst  (rst),
    .clr  (place_fire || respawn),
    .en   (1'b1),
    .done (place_done)
  );

  cd_counter #(.LIMIT(REFILL_CD)) u_refill_cd (
    .clk  (clk),
    .rst  (rst),
    .clr  (refill_fire || !refill_en || respawn),
    .en   (refill_en),
    .done (refill_done)
  );

`ifdef PLAYER_RESPAWN_EN
  // Life-state timers; each restarts from 0 on entry to its state.
  cd_counter #(.LIMIT(RESPAWN_CD)) u_respawn_cd (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != DEAD),
    .en   (state_q == DEAD),
    .done (respawn_done)
  );

  cd_counter #(.LIMIT(INVULN_CD)) u_invuln_cd (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != INVULN),
    .en   (state_q == INVULN),
    .done (invuln_done)
  );
`else
  assign respawn_done = 1'b0;
  assign invuln_done  = 1'b0;
`endif

  assign respawn = (state_q == DEAD) && respawn_done;

  // Actions are allowed when not dead, except in the cycle a hit kills us.
  assign act = CFG_OK &&
               (((state_q == ALIVE) && !bus.hit) || (state_q == INVULN));

  // Target tile of the highest-priority pressed direction (signed, may be off-map).
  always_comb begin : target_sel
    th      = int'(curh_q);
    tv      = int'(curv_q);
    dir_req = 1'b0;
    if (bus.up) begin
      dir_req = 1'b1;
      tv      = int'(curv_q) - 1;
    end else if (bus.down) begin
      dir_req = 1'b1;
      tv      = int'(curv_q) + 1;
    end else if (bus.left) begin
      dir_req = 1'b1;
      th      = int'(curh_q) - 1;
    end else if (bus.right) begin
      dir_req = 1'b1;
      th      = int'(curh_q) + 1;
    end
  end

  assign in_bounds = (th >= 0) && (th < int'(HTILES)) &&
                     (tv >= 0) && (tv < int'(VTILES));
  assign tile_idx  = IW'(int'(HTILES) * tv + th);
  assign walk_ok   = in_bounds && bus.walkAble[tile_idx];

  assign move_fire   = act && move_done && dir_req && walk_ok;
  assign place_fire  = act && place_done && bus.attack &&
                       (numbomb_q != '0) && !bus.bombHere;
  assign refill_en   = (numbomb_q < FULL) && (state_q != DEAD);
  assign refill_fire = act && refill_en && refill_done;

  // Next-state and next-output logic.
  always_comb begin : next_state
    state_d     = state_q;
    curh_d      = curh_q;
    curv_d      = curv_q;
    numbomb_d   = numbomb_q;
    placebomb_d = 1'b0;
    bombh_d     = bombh_q;
    bombv_d     = bombv_q;

    unique case (state_q)
      ALIVE:   if (bus.hit)     state_d = DEAD;
      DEAD:    if (respawn)     state_d = INVULN;
      INVULN:  if (invuln_done) state_d = ALIVE;
      default:                  state_d = ALIVE;
    endcase

    if (move_fire) begin
      curh_d = HW'(th);
      curv_d = VW'(tv);
    end

    // Bomb lands on the tile held before any same-cycle step.
    if (place_fire) begin
      placebomb_d = 1'b1;
      bombh_d     = curh_q;
      bombv_d     = curv_q;
    end

    // A drop and a refill in the same cycle cancel out.
    if (place_fire && !refill_fire) begin
      numbomb_d = numbomb_q - NUMBOMB_W'(1);
    end else if (refill_fire && !place_fire) begin
      numbomb_d = numbomb_q + NUMBOMB_W'(1);
    end

    if (respawn) begin
      curh_d    = HW'(START_H);
      curv_d    = VW'(START_V);
      numbomb_d = FULL;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q     <= ALIVE;
      curh_q      <= HW'(START_H);
      curv_q      <= VW'(START_V);
      numbomb_q   <= FULL;
      placebomb_q <= 1'b0;
      bombh_q     <= '0;
      bombv_q     <= '0;
    end else begin
      state_q     <= state_d;
      curh_q      <= curh_d;
      curv_q      <= curv_d;
      numbomb_q   <= numbomb_d;
      placebomb_q <= placebomb_d;
      bombh_q     <= bombh_d;
      bombv_q     <= bombv_d;
    end
  end

  assign bus.curh      = curh_q;
  assign bus.curv      = curv_q;
  assign bus.placeBomb = placebomb_q;
  assign bus.bombh     = bombh_q;
  assign bus.bombv     = bombv_q;
  assign bus.numBomb   = numbomb_q;
  assign bus.state     = STATE_W'(state_q);

endmodule

// File: tb/tb_player_ctrl.sv
// Randomized scoreboard bench for player_ctrl on a 4x3 map with short cooldowns.
module tb_player_ctrl;
  import player_pkg::*;

  localparam int H          = 4;
  localparam int V          = 3;
  localparam int MOVE_CD    = 4;
  localparam int PLACE_CD   = 3;
  localparam int REFILL_CD  = 8;
  localparam int RESPAWN_CD = 5;
  localparam int INVULN_CD  = 6;
  localparam int MAXB       = 2;
  localparam int SH         = 0;
  localparam int SV         = 0;

  typedef struct {
    int en;
    int h, v, pb, bh, bv, nb, st;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  logic rst;
  logic [H*V-1:0] walk;

  always #5 clk = ~clk;

  player_if #(.HTILES(H), .VTILES(V)) bus ();

  player_ctrl #(
    .HTILES(H), .VTILES(V), .MAXBOMB(MAXB), .START_H(SH), .START_V(SV),
    .MOVE_CD(MOVE_CD), .PLACE_CD(PLACE_CD), .REFILL_CD(REFILL_CD),
    .RESPAWN_CD(RESPAWN_CD), .INVULN_CD(INVULN_CD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int en, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, en, act, exp);
    end
  endtask

  // Reference model: cooldowns expressed as "edges since last event".
  int m_h, m_v, m_pb, m_bh, m_bv, m_nb, m_st;
  int e = 0;
  int last_mv, last_pl, refill_since, st_since;

  task automatic model(input bit r, input bit u, input bit d, input bit l, input bit rt,
                       input bit a, input bit bh, input bit ht);
    bit active, running, do_place, do_refill, do_move;
    int dh, dv, nh, nv;
    e++;
    if (r) begin
      m_h = SH; m_v = SV; m_nb = MAXB; m_st = 0; m_pb = 0; m_bh = 0; m_bv = 0;
      last_mv = e; last_pl = e; refill_since = e; st_since = e;
      return;
    end
    active    = (m_st == 0 && !ht) || m_st == 2;
    running   = (m_nb < MAXB) && (m_st != 1);
    do_place  = active && (e - last_pl >= PLACE_CD) && a && (m_nb > 0) && !bh;
    do_refill = active && running && (e - refill_since >= REFILL_CD);
    dh = 0; dv = 0;
    if (u) dv = -1;
    else if (d) dv = 1;
    else if (l) dh = -1;
    else if (rt) dh = 1;
    nh = m_h + dh;
    nv = m_v + dv;
    do_move = active && (dh != 0 || dv != 0) && (e - last_mv >= MOVE_CD) &&
              nh >= 0 && nh < H && nv >= 0 && nv < V &&
              (((walk >> (nv * H + nh)) & 1) != 0);
    m_pb = do_place ? 1 : 0;
    if (do_place) begin
      m_bh = m_h; m_bv = m_v; last_pl = e; m_nb--;
    end
    if (do_refill) m_nb++;
    if (!running || do_refill) refill_since = e;
    if (do_move) begin
      m_h = nh; m_v = nv; last_mv = e;
    end
    if (m_st == 0) begin
      if (ht) begin
        m_st = 1; st_since = e;
      end
    end else if (m_st == 1) begin
`ifdef PLAYER_RESPAWN_EN
      if (e - st_since >= RESPAWN_CD) begin
        m_st = 2; st_since = e;
        m_h = SH; m_v = SV; m_nb = MAXB;
        last_mv = e; last_pl = e; refill_since = e;
      end
`endif
    end else if (m_st == 2) begin
      if (e - st_since >= INVULN_CD) m_st = 0;
    end
  endtask

  // Drive one cycle of inputs, push the outcome expected after the next edge.
  task automatic cyc(input bit r, input bit u, input bit d, input bit l, input bit rt,
                     input bit a, input bit bh, input bit ht);
    exp_t x;
    rst = r;
    bus.up = u; bus.down = d; bus.left = l; bus.right = rt;
    bus.attack = a; bus.bombHere = bh; bus.hit = ht;
    bus.walkAble = walk;
    model(r, u, d, l, rt, a, bh, ht);
    x.en = e; x.h = m_h; x.v = m_v; x.pb = m_pb; x.bh = m_bh; x.bv = m_bv;
    x.nb = m_nb; x.st = m_st;
    q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: every edge produces a new registered output set.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("curh",      x.en, 32'(bus.curh),      x.h);
        chk("curv",      x.en, 32'(bus.curv),      x.v);
        chk("placeBomb", x.en, 32'(bus.placeBomb), x.pb);
        chk("bombh",     x.en, 32'(bus.bombh),     x.bh);
        chk("bombv",     x.en, 32'(bus.bombv),     x.bv);
        chk("numBomb",   x.en, 32'(bus.numBomb),   x.nb);
        chk("state",     x.en, 32'(bus.state),     x.st);
      end
    end
  end

  initial begin : driver
    walk = '1;

    // Hold right on an open map: steps at edges 4, 8, 12, then wall.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("abs_right_edge", e, 32'(bus.curh), 3);

    // Tile (1,0) blocked: right never moves, down at edge 6 goes through.
    walk = '1;
    walk[1] = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("abs_blocked", e, 32'(bus.curh), 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("abs_down_now", e, 32'(bus.curv), 1);
    walk = '1;

    // Held attack: pulses at 3 and 6, empty, refill at 11.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // Attack blocked by bombHere, then released.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("abs_pulse_after_clear", e, 32'(bus.placeBomb), 1);

    // Walk to (2,1), get hit, then sit through the death/respawn window.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("abs_dead", e, 32'(bus.state), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PLAYER_RESPAWN_EN
    chk("abs_respawn_state", e, 32'(bus.state), 0);
    chk("abs_respawn_h", e, 32'(bus.curh), 0);
    chk("abs_respawn_nb", e, 32'(bus.numBomb), 2);
`else
    chk("abs_dead_state", e, 32'(bus.state), 1);
    chk("abs_dead_h", e, 32'(bus.curh), 2);
    chk("abs_dead_v", e, 32'(bus.curv), 1);
`endif

    // Randomized traffic with occasional hits and mid-run resets.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit r, u, d, l, rt, a, bh, ht;
      if (i % 40 == 0) walk = (H*V)'($urandom) | (H*V)'($urandom);
      r  = ($urandom_range(0, 149) == 0);
      u  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 1) == 0);
      bh = ($urandom_range(0, 3) == 0);
      ht = ($urandom_range(0, 24) == 0);
      cyc(r, u, d, l, rt, a, bh, ht);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("queue_drained", e, 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Parametrised grid-player controller for the VGA bomber game: tracks one player's tile position on an HTILES×VTILES map, gates movement through a walkability mask, and manages a refilling bomb inventory. It adds a life-state machine (alive / dead / invulnerable-respawn) driven by an explosion-hit input. It sits between the keyboard decoder (direction/attack levels) and the map/bomb engine, which consumes the position and placement pulse.

## Interface
- HTILES, 10: map width in tiles (≥2); HW = $clog2(HTILES)
- VTILES, 6: map height in tiles (≥2); VW = $clog2(VTILES)
- MAXBOMB, 10: inventory capacity (1..15)
- START_H / START_V, 0 / 0: spawn tile
- MOVE_CD, 2**24: cycles between accepted steps
- PLACE_CD, 2**22: cycles between accepted placements
- REFILL_CD, 2**26: cycles per +1 bomb refill
- RESPAWN_CD, 2**27: dead time before respawn (macro only)
- INVULN_CD, 2**26: post-respawn hit immunity (macro only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- up, down, left, right  in  1  direction levels
- attack  in  1  place-bomb request level
- walkAble  in  HTILES*VTILES  bit HTILES*v+h = 1 means tile (h,v) enterable
- bombHere  in  1  a bomb already occupies (curh,curv)
- hit  in  1  explosion covers player tile this cycle
- curh / curv  out  HW / VW  current tile
- placeBomb  out  1  one-cycle placement pulse
- bombh / bombv  out  HW / VW  tile of last placement
- numBomb  out  4  bombs in hand
- state  out  2  0 ALIVE, 1 DEAD, 2 INVULN

## Operation
- All outputs registered. Reset: curh=START_H, curv=START_V, numBomb=MAXBOMB, placeBomb=0, bombh=bombv=0, state=ALIVE, all counters 0.
- Move counter: saturates at MOVE_CD-1; step allowed only when saturated and state≠DEAD. One axis per step, priority up > down > left > right (only highest pressed considered). Target must be in-bounds and walkAble=1, else no move, counter stays saturated. Accepted step clears counter.
- Place counter: saturates at PLACE_CD-1. Placement when saturated ∧ attack ∧ numBomb>0 ∧ !bombHere ∧ state≠DEAD: placeBomb=1 next cycle, bombh/bombv ← curh/curv, numBomb−1, counter cleared. Held attack places again only after PLACE_CD.
- Refill counter: runs only while numBomb<MAXBOMB and state≠DEAD, held 0 otherwise. At REFILL_CD-1: numBomb+1, counter cleared.
- Same-cycle placement + refill: numBomb unchanged, both counters cleared, placeBomb still pulses.
- Same-cycle move + placement: bomb goes to pre-move tile.
- ALIVE + hit → DEAD next cycle; move/place suppressed that cycle. In DEAD, position and numBomb frozen; hit ignored.
- numBomb never exceeds MAXBOMB nor underflows; position never leaves 0..HTILES-1 / 0..VTILES-1.

## Timing
- Input-to-output latency 1 cycle for move, placement, state change.
- First step after reset possible at cycle MOVE_CD (counter 0..MOVE_CD-1); same rule for PLACE_CD.
- rst mid-operation overrides everything in the same edge, including a pending DEAD/INVULN timer.

## Configuration
- PLAYER_RESPAWN_EN defined: DEAD counts RESPAWN_CD cycles, then → INVULN with curh/curv=START, numBomb=MAXBOMB, all cooldown counters cleared; INVULN behaves as ALIVE but ignores hit, → ALIVE after INVULN_CD cycles.
- Undefined: DEAD is terminal until rst; INVULN never entered; RESPAWN_CD/INVULN_CD unused.

## Structure
- Package player_pkg: player_state_t enum (ALIVE, DEAD, INVULN), state width constant, MAXBOMB ceiling constant 15.
- Sub-module cd_counter (parametrised LIMIT; inputs clr, en; output done = saturated), instantiated for move, place, refill, and state timer.

## Test plan
(Bench overrides HTILES=4, VTILES=3, MOVE_CD=4, PLACE_CD=3, REFILL_CD=8, RESPAWN_CD=5, INVULN_CD=6, MAXBOMB=2.)
- Reset, hold right, all walkable → curh 0→1→2→3 at cycles 4, 8, 12; stays 3 at edge.
- walkAble bit 1 cleared, hold right → curh stays 0; release, press down at cycle 6 → curv=1 next cycle (counter saturated).
- Hold attack from reset → placeBomb pulses at cycles 3 and 6, numBomb 2→1→0, no third pulse; refill returns numBomb to 1 eight cycles after first drop below MAXBOMB, counting from that drop.
- attack with bombHere=1 → no pulse, numBomb unchanged; deassert bombHere → pulse next cycle.
- hit while ALIVE at tile (2,1) → state=DEAD; with PLAYER_RESPAWN_EN: 5 cycles later INVULN at (0,0), numBomb=2, hit ignored for 6 cycles then ALIVE; without macro: stays DEAD, inputs ignored until rst.
